// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               hit_o,
  output logic [IW-1:0]      idx_o
);

  // Scan from the farthest offset down so the nearest hit after last_i wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % NUM_REQ]) begin
        hit_o = 1'b1;
        idx_o = IW'((int'(last_i) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the dual_clock_fifo write port.
// Optional per-requester word counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wr_clk_i,
  input  logic                          wr_rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic                          busy_o,
  output logic [idx_width(NUM_REQ)-1:0] grant_idx_o
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         word_cnt_o
`endif
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(BURST_LEN);

  // Handshake: a word moves when req_valid_i[g] and req_ready_o[g] are both
  // high at the clock edge; ready never depends on valid.
  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0] r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_hit;
  logic [IW-1:0] w_pick;
  logic          w_active;
  logic          w_valid_g;
  logic          w_accept;
  logic          w_burst_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i  (req_valid_i),
    .last_i (r_last),
    .hit_o  (w_hit),
    .idx_o  (w_pick)
  );

  // Reset gates the outputs so an in-flight word is dropped, not written.
  assign w_active     = (r_state == BURST) && !wr_rst_i;
  assign w_valid_g    = req_valid_i[r_grant];
  assign w_accept     = w_active && w_valid_g && !fifo_full_i;
  assign w_burst_done = (r_cnt == CW'(BURST_LEN - 1));

  always_comb begin
    req_ready_o = '0;
    if (w_active && !fifo_full_i) begin
      req_ready_o[r_grant] = 1'b1;
    end
  end

  assign fifo_wr_en_o   = w_accept;
  assign fifo_wr_data_o = req_data_i[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign busy_o         = (r_state == BURST);
  assign grant_idx_o    = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = BURST;
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (fifo_full_i) begin
          w_state_nxt = BURST;
        end else if (w_valid_g) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_burst_done) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_grant;
          end
        end else begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk_i) begin
    if (wr_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_word_cnt [NUM_REQ];

  always_ff @(posedge wr_clk_i) begin
    if (wr_rst_i) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        r_word_cnt[n] <= '0;
      end
    end else if (w_accept) begin
      r_word_cnt[r_grant] <= r_word_cnt[r_grant] + 16'd1;
    end
  end

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_cnt_out
    assign word_cnt_o[n*16 +: 16] = r_word_cnt[n];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=16).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  ready;
  logic        full = 1'b0;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        busy;
  logic [1:0]  grant;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (16),
    .BURST_LEN  (4)
  ) dut (
    .wr_clk_i       (clk),
    .wr_rst_i       (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (ready),
    .fifo_full_i    (full),
    .fifo_wr_en_o   (wr_en),
    .fifo_wr_data_o (wr_data),
    .busy_o         (busy),
    .grant_idx_o    (grant)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .word_cnt_o     (word_cnt)
`endif
  );

  // Source model: per-requester word lists, valid while words remain.
  logic [15:0] src_mem [4][8];
  int          src_n [4];
  int          src_rd [4];
  int          cyc;
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] wr_data_q [$];
  int          wr_cyc_q [$];
  logic [15:0] exp_q [$];
  int          exp_cyc_q [$];
  logic        s_wr_en;
  logic [3:0]  s_ready;
  logic        s_busy;
  logic [1:0]  s_grant;

  task automatic drive_inputs();
    for (int n = 0; n < 4; n++) begin
      if (src_rd[n] < src_n[n]) begin
        req_valid[n]         = 1'b1;
        req_data[n*16 +: 16] = src_mem[n][src_rd[n]];
      end else begin
        req_valid[n]         = 1'b0;
        req_data[n*16 +: 16] = 16'h0000;
      end
    end
  endtask

  task automatic load_src(input int n, input int count, input logic [15:0] base);
    for (int k = 0; k < 8; k++) src_mem[n][k] = base + 16'(k);
    src_n[n]  = count;
    src_rd[n] = 0;
  endtask

  task automatic clear_all();
    for (int n = 0; n < 4; n++) begin
      src_n[n]  = 0;
      src_rd[n] = 0;
    end
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // One clock: sample at negedge, then retire accepted words after the edge.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    s_wr_en = wr_en;
    s_ready = ready;
    s_busy  = busy;
    s_grant = grant;
    if (wr_en) begin
      wr_data_q.push_back(wr_data);
      wr_cyc_q.push_back(cyc);
    end
    acc = ready & req_valid;
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 4; n++) if (acc[n]) src_rd[n]++;
    drive_inputs();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    full = 1'b0;
    clear_all();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    clear_all();
    for (int n = 0; n < 4; n++) load_src(n, 4, 16'(n * 256));
    rst = 1'b1;
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else n_pass++;
      n_total++; if (ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (grant !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant); else n_pass++;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    load_src(0, 4, 16'h0A01);
    drive_inputs();
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %b want 0", wr_en); else n_pass++;
    n_total++; if (ready !== 4'b0000) $display("FAIL midrst_ready: got %b want 0000", ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy_after: got %b want 0", busy); else n_pass++;
    n_total++; if (wr_data_q.size() != 2) $display("FAIL midrst_nwrites: got %0d want 2", wr_data_q.size()); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_stream_one();
    do_reset();
    load_src(2, 6, 16'h0201);
    drive_inputs();
    repeat (10) step();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(16'h0201 + 16'(i));
      exp_cyc_q.push_back((i < 4) ? 1 + i : 2 + i);
    end
    n_total++; if (wr_data_q.size() != 6) $display("FAIL stream_nwrites: got %0d want 6", wr_data_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < wr_data_q.size(); i++) begin
      n_total++; if (wr_data_q[i] !== exp_q[i]) $display("FAIL stream_data[%0d]: got %h want %h", i, wr_data_q[i], exp_q[i]); else n_pass++;
      n_total++; if (wr_cyc_q[i] != exp_cyc_q[i]) $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, wr_cyc_q[i], exp_cyc_q[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 4; n++) load_src(n, 8, 16'(n * 256 + 1));
    drive_inputs();
    for (int c = 0; c < 25; c++) begin
      step();
      n_total++; if (!$onehot0(s_ready)) $display("FAIL b2b_ready_onehot: got %b want at most one bit", s_ready); else n_pass++;
    end
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(16'(((i / 4) % 4) * 256 + 1 + (i / 16) * 4 + (i % 4)));
      exp_cyc_q.push_back(1 + (i / 4) * 5 + (i % 4));
    end
    n_total++; if (wr_data_q.size() != 20) $display("FAIL b2b_nwrites: got %0d want 20", wr_data_q.size()); else n_pass++;
    for (int i = 0; i < 20 && i < wr_data_q.size(); i++) begin
      n_total++; if (wr_data_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, wr_data_q[i], exp_q[i]); else n_pass++;
      n_total++; if (wr_cyc_q[i] != exp_cyc_q[i]) $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, wr_cyc_q[i], exp_cyc_q[i]); else n_pass++;
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    load_src(0, 4, 16'h0A01);
    drive_inputs();
    repeat (3) step();
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (s_wr_en !== 1'b0) $display("FAIL full_wr_en: got %b want 0", s_wr_en); else n_pass++;
      n_total++; if (s_ready !== 4'b0000) $display("FAIL full_ready: got %b want 0000", s_ready); else n_pass++;
      n_total++; if (s_grant !== 2'd0) $display("FAIL full_grant: got %0d want 0", s_grant); else n_pass++;
      n_total++; if (s_busy !== 1'b1) $display("FAIL full_busy: got %b want 1", s_busy); else n_pass++;
    end
    full = 1'b0;
    repeat (5) step();
    exp_cyc_q = '{1, 2, 6, 7};
    n_total++; if (wr_data_q.size() != 4) $display("FAIL full_nwrites: got %0d want 4", wr_data_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
      n_total++; if (wr_data_q[i] !== 16'h0A01 + 16'(i)) $display("FAIL full_data[%0d]: got %h want %h", i, wr_data_q[i], 16'h0A01 + 16'(i)); else n_pass++;
      n_total++; if (wr_cyc_q[i] != exp_cyc_q[i]) $display("FAIL full_cycle[%0d]: got %0d want %0d", i, wr_cyc_q[i], exp_cyc_q[i]); else n_pass++;
    end
  endtask

  task automatic test_valid_drop();
    do_reset();
    load_src(1, 2, 16'h0101);
    load_src(3, 4, 16'h0301);
    drive_inputs();
    repeat (3) step();
    step();
    n_total++; if (s_wr_en !== 1'b0) $display("FAIL drop_wr_en: got %b want 0", s_wr_en); else n_pass++;
    n_total++; if (s_busy !== 1'b1) $display("FAIL drop_busy_c3: got %b want 1", s_busy); else n_pass++;
    n_total++; if (s_grant !== 2'd1) $display("FAIL drop_grant_c3: got %0d want 1", s_grant); else n_pass++;
    step();
    n_total++; if (s_busy !== 1'b0) $display("FAIL drop_idle_c4: got %b want 0", s_busy); else n_pass++;
    step();
    n_total++; if (s_grant !== 2'd3) $display("FAIL drop_grant_c5: got %0d want 3", s_grant); else n_pass++;
    repeat (5) step();
    exp_q     = '{16'h0101, 16'h0102, 16'h0301, 16'h0302, 16'h0303, 16'h0304};
    exp_cyc_q = '{1, 2, 5, 6, 7, 8};
    n_total++; if (wr_data_q.size() != 6) $display("FAIL drop_nwrites: got %0d want 6", wr_data_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < wr_data_q.size(); i++) begin
      n_total++; if (wr_data_q[i] !== exp_q[i]) $display("FAIL drop_data[%0d]: got %h want %h", i, wr_data_q[i], exp_q[i]); else n_pass++;
      n_total++; if (wr_cyc_q[i] != exp_cyc_q[i]) $display("FAIL drop_cycle[%0d]: got %0d want %0d", i, wr_cyc_q[i], exp_cyc_q[i]); else n_pass++;
    end
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    load_src(0, 5, 16'h0001);
    load_src(3, 5, 16'h0301);
    drive_inputs();
    repeat (20) step();
    n_total++; if (word_cnt[15:0] !== 16'd5) $display("FAIL stats_cnt0: got %0d want 5", word_cnt[15:0]); else n_pass++;
    n_total++; if (word_cnt[31:16] !== 16'd0) $display("FAIL stats_cnt1: got %0d want 0", word_cnt[31:16]); else n_pass++;
    n_total++; if (word_cnt[47:32] !== 16'd0) $display("FAIL stats_cnt2: got %0d want 0", word_cnt[47:32]); else n_pass++;
    n_total++; if (word_cnt[63:48] !== 16'd5) $display("FAIL stats_cnt3: got %0d want 5", word_cnt[63:48]); else n_pass++;
  endtask
`endif

  initial begin
    cyc = 0;
    test_reset();
    test_mid_burst_reset();
    test_stream_one();
    test_back_to_back();
    test_full_stall();
    test_valid_drop();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of `dual_clock_fifo` among `NUM_REQ` producers in the write-clock domain. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` words and drives the FIFO write enable and data directly. It never writes while the FIFO reports full.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 16: word width; matches the FIFO `DATA_WIDTH`.
- `BURST_LEN`, 4: maximum words per grant, 1..256.

- `wr_clk_i`  in  1: write-domain clock, the same clock as the FIFO write side.
- `wr_rst_i`  in  1: synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ: per-requester valid.
- `req_data_i`  in  NUM_REQ*DATA_WIDTH: requester n's word is at `[n*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready_o`  out  NUM_REQ: per-requester ready; at most one bit is set.
- `fifo_full_i`  in  1: the FIFO `full_o`.
- `fifo_wr_en_o`  out  1: to the FIFO `wr_en_i`.
- `fifo_wr_data_o`  out  DATA_WIDTH: to the FIFO `wr_data_i`.
- `busy_o`  out  1: high while a grant is held (state BURST).
- `grant_idx_o`  out  $clog2(NUM_REQ): index of the current or last granted requester.

## Operation
- State machine, IDLE and BURST; reset state is IDLE.
- IDLE:
  - Search `req_valid_i` starting at `last+1` and wrapping modulo `NUM_REQ`.
  - On a hit, register `grant_idx_o`, clear the burst counter and go to BURST.
  - No transfer happens in an IDLE cycle.
- BURST:
  - `req_ready_o[g] = !fifo_full_i`; all other ready bits are 0.
  - A word is accepted when `req_valid_i[g] & req_ready_o[g]`.
  - `fifo_wr_en_o` equals the accept condition; `fifo_wr_data_o` equals the slice for g.
  - The burst counter increments on each accept.
- BURST exit to IDLE, with `last` updated to g:
  - (a) an accept that makes the counter reach `BURST_LEN`; or
  - (b) `req_valid_i[g]` is low in a BURST cycle, and no transfer happens that cycle.
- Full stall: while `fifo_full_i` is high in BURST, grant, counter and state hold. There is no timeout.
- Fairness: after any exit the just-served requester has the lowest priority.
- `fifo_wr_data_o` is don't-care when `fifo_wr_en_o` is 0, but is driven from the grant mux, not with X.
- Burst counter width is `$clog2(BURST_LEN+1)`. It never wraps, because exit (a) happens at equality.

## Timing
- Reset values:
  - state IDLE; `last = NUM_REQ-1` so requester 0 wins first.
  - `grant_idx_o = 0`, `busy_o = 0`, burst counter 0.
  - `fifo_wr_en_o = 0` and `req_ready_o = 0`. These outputs are combinational but gated by state, so they are 0 in reset.
- Reset asserted mid-burst: next edge returns to IDLE. The in-flight word of that cycle is not written, because the outputs are gated by `!wr_rst_i`.
- Arbitration latency: 1 cycle. A valid seen in IDLE gives its first write on the next edge.
- Throughput: a full `BURST_LEN` burst takes `BURST_LEN+1` cycles including the IDLE bubble.
- `fifo_full_i` is used combinationally in the same cycle. This is safe because the FIFO updates `full_o` on the write edge.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined:
  - Adds output `word_cnt_o`  out  NUM_REQ*16, one counter per requester.
  - Each counter increments on every accepted word from that requester and wraps 0xFFFF to 0. Reset value 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_t` enum {IDLE, BURST}.
  - Width helper functions for the index and counter.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: request vector and `last`. Outputs: hit and index.

## Test plan
Common setup: `NUM_REQ=4`, `BURST_LEN=4`, `DATA_WIDTH=16`.
- Reset hold: `wr_rst_i=1` for 3 cycles with all valid high -> `fifo_wr_en_o=0`, `req_ready_o=0000`, `busy_o=0`, `grant_idx_o=0`.
- Requester 2 streams 6 words 0x0201..0x0206 -> words 1-4 written on consecutive cycles starting 1 cycle after valid; 1 IDLE bubble; then 0x0205 and 0x0206.
- All four valid continuously -> grant order 0,1,2,3,0, each 4 words, 5 cycles per grant.
- `fifo_full_i=1` for 3 cycles after the second word of a burst -> no writes, ready low, `grant_idx_o` unchanged; words 3-4 follow when full clears.
- Requester 1 drops valid after 2 words while 3 is valid -> IDLE next cycle, then grant to 3.
- `FIFO_WR_ARB_STATS_EN` build, 5 words each from 0 and 3 -> `word_cnt_o` slices equal 5,0,0,5.
